// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the load/store opcode encodings (inst[31:26]), the FSM state
// encoding and the big-endian byte-lane select patterns.
package mem_access_stage_pkg;

  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpSb  = 6'b101000;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSw  = 6'b101011;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  // Big-endian: byte address 0 lives in bits [31:24].
  localparam logic [3:0] SelByte0  = 4'b1000;
  localparam logic [3:0] SelByte1  = 4'b0100;
  localparam logic [3:0] SelByte2  = 4'b0010;
  localparam logic [3:0] SelByte3  = 4'b0001;
  localparam logic [3:0] SelHalfHi = 4'b1100;
  localparam logic [3:0] SelHalfLo = 4'b0011;
  localparam logic [3:0] SelWord   = 4'b1111;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OpLb) || (op == OpLh) || (op == OpLw) || (op == OpLbu) || (op == OpLhu);
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the MEM stage.
// Ports:
//   op_i          opcode inst[31:26]
//   addr_lo_i     effective address bits [1:0]
//   store_data_i  raw store data (reg2)
//   rdata_i       raw bus read data
//   sel_o         byte-lane select
//   wdata_o       store data replicated across all lanes
//   rdata_ext_o   selected lane, sign- or zero-extended
//   misaligned_o  half with addr[0]=1 or word with addr[1:0]!=0
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_ext_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [3:0]  byte_sel;

  always_comb begin
    unique case (addr_lo_i)
      2'b00: begin byte_lane = rdata_i[31:24]; byte_sel = SelByte0; end
      2'b01: begin byte_lane = rdata_i[23:16]; byte_sel = SelByte1; end
      2'b10: begin byte_lane = rdata_i[15:8];  byte_sel = SelByte2; end
      default: begin byte_lane = rdata_i[7:0]; byte_sel = SelByte3; end
    endcase
    half_lane = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  always_comb begin
    sel_o        = 4'b0000;
    wdata_o      = store_data_i;
    rdata_ext_o  = rdata_i;
    misaligned_o = 1'b0;
    case (op_i)
      OpLb, OpLbu, OpSb: begin
        sel_o       = byte_sel;
        wdata_o     = {4{store_data_i[7:0]}};
        rdata_ext_o = (op_i == OpLb) ? {{24{byte_lane[7]}}, byte_lane} : {24'b0, byte_lane};
      end
      OpLh, OpLhu, OpSh: begin
        sel_o        = addr_lo_i[1] ? SelHalfLo : SelHalfHi;
        wdata_o      = {2{store_data_i[15:0]}};
        rdata_ext_o  = (op_i == OpLh) ? {{16{half_lane[15]}}, half_lane} : {16'b0, half_lane};
        misaligned_o = addr_lo_i[0];
      end
      OpLw, OpSw: begin
        sel_o        = SelWord;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage. Loads/stores run a req/ack handshake on the data bus
// while the pipeline is stalled; everything else passes straight through.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   aluop_i, mem_addr_i, reg2_i      opcode, effective address, store data
//   wd_i, wreg_i, wdata_i            register writeback in
//   whilo_i, hi_i, lo_i              HI/LO writeback in
//   cp0_reg_*_i                      CP0 writeback in
//   bus_rdata_i, bus_ack_i           data bus response
//   bus_req_o, bus_we_o, bus_addr_o,
//   bus_sel_o, bus_wdata_o           data bus request (registered)
//   stall_req_o                      stall request to pipeline control
//   wd_o, wreg_o, wdata_o            register writeback out
//   whilo_o, hi_o, lo_o              HI/LO writeback out
//   cp0_reg_*_o                      CP0 writeback out
//   excp_adel_o, excp_ades_o         misaligned load / store
//   bus_err_o                        one-cycle timeout pulse
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        cp0_reg_we_i,
  input  logic [4:0]  cp0_reg_write_addr_i,
  input  logic [31:0] cp0_reg_data_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  output logic        stall_req_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        cp0_reg_we_o,
  output logic [4:0]  cp0_reg_write_addr_o,
  output logic [31:0] cp0_reg_data_o,
  output logic        excp_adel_o,
  output logic        excp_ades_o,
  output logic        bus_err_o
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        misaligned;
  logic        is_load;
  logic        is_store;
  logic        is_mem;

  mem_state_e  state_q;
  logic [15:0] cnt_q;
  logic [31:0] result_q;
  logic        err_flag_q;
  logic        bus_err_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_sel_q;
  logic [31:0] bus_wdata_q;

  mem_lane_align u_lane_align (
    .op_i         (aluop_i),
    .addr_lo_i    (mem_addr_i[1:0]),
    .store_data_i (reg2_i),
    .rdata_i      (bus_rdata_i),
    .sel_o        (lane_sel),
    .wdata_o      (lane_wdata),
    .rdata_ext_o  (lane_rdata),
    .misaligned_o (misaligned)
  );

  assign is_load  = is_load_op(aluop_i);
  assign is_store = is_store_op(aluop_i);
  assign is_mem   = is_load | is_store;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      result_q    <= '0;
      err_flag_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (is_mem && !misaligned) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= is_store;
            bus_addr_q  <= {mem_addr_i[31:2], 2'b00};
            bus_sel_q   <= lane_sel;
            bus_wdata_q <= lane_wdata;
            cnt_q       <= '0;
            err_flag_q  <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (bus_ack_i) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            // Inputs are frozen by the stall, so the live opcode still applies.
            result_q  <= is_load ? lane_rdata : wdata_i;
            state_q   <= StDone;
          end else if (cnt_q == TimeoutLast) begin
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_err_q  <= 1'b1;
            err_flag_q <= 1'b1;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    stall_req_o          = 1'b0;
    wd_o                 = wd_i;
    wreg_o               = wreg_i;
    wdata_o              = wdata_i;
    whilo_o              = whilo_i;
    hi_o                 = hi_i;
    lo_o                 = lo_i;
    cp0_reg_we_o         = cp0_reg_we_i;
    cp0_reg_write_addr_o = cp0_reg_write_addr_i;
    cp0_reg_data_o       = cp0_reg_data_i;
    excp_adel_o          = 1'b0;
    excp_ades_o          = 1'b0;
    bus_req_o            = bus_req_q;
    bus_we_o             = bus_we_q;
    bus_addr_o           = bus_addr_q;
    bus_sel_o            = bus_sel_q;
    bus_wdata_o          = bus_wdata_q;
    bus_err_o            = bus_err_q;

    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          // Writeback is suppressed until the access result is available.
          wreg_o = 1'b0;
          if (misaligned) begin
            excp_adel_o = is_load;
            excp_ades_o = is_store;
          end else begin
            stall_req_o = 1'b1;
          end
        end
      end
      StWait: begin
        stall_req_o = 1'b1;
        wreg_o      = 1'b0;
      end
      StDone: begin
        wdata_o = result_q;
        wreg_o  = wreg_i & ~err_flag_q;
      end
      default: ;
    endcase

    if (rst) begin
      stall_req_o          = 1'b0;
      wd_o                 = '0;
      wreg_o               = 1'b0;
      wdata_o              = '0;
      whilo_o              = 1'b0;
      hi_o                 = '0;
      lo_o                 = '0;
      cp0_reg_we_o         = 1'b0;
      cp0_reg_write_addr_o = '0;
      cp0_reg_data_o       = '0;
      excp_adel_o          = 1'b0;
      excp_ades_o          = 1'b0;
      bus_req_o            = 1'b0;
      bus_we_o             = 1'b0;
      bus_addr_o           = '0;
      bus_sel_o            = '0;
      bus_wdata_o          = '0;
      bus_err_o            = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int unsigned Tmo = 4;
  localparam logic [5:0] OpAddu = 6'b000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, hi_i, lo_i, cp0_reg_data_i, bus_rdata_i;
  logic [4:0]  wd_i, cp0_reg_write_addr_i;
  logic        wreg_i, whilo_i, cp0_reg_we_i, bus_ack_i;
  logic        bus_req_o, bus_we_o, stall_req_o, wreg_o, whilo_o, cp0_reg_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, wdata_o, hi_o, lo_o, cp0_reg_data_o;
  logic [3:0]  bus_sel_o;
  logic [4:0]  wd_o, cp0_reg_write_addr_o;
  logic        excp_adel_o, excp_ades_o, bus_err_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] wdata;
    logic        wreg;
    logic [3:0]  sel;
    logic [31:0] bwdata;
    logic [31:0] baddr;
    logic        we;
    int          stalls;
    int          req_cycles;
    int          err_cycles;
  } txn_t;

  txn_t sb_q[$];

  mem_access_stage #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .aluop_i              (aluop_i),
    .mem_addr_i           (mem_addr_i),
    .reg2_i               (reg2_i),
    .wd_i                 (wd_i),
    .wreg_i               (wreg_i),
    .wdata_i              (wdata_i),
    .whilo_i              (whilo_i),
    .hi_i                 (hi_i),
    .lo_i                 (lo_i),
    .cp0_reg_we_i         (cp0_reg_we_i),
    .cp0_reg_write_addr_i (cp0_reg_write_addr_i),
    .cp0_reg_data_i       (cp0_reg_data_i),
    .bus_rdata_i          (bus_rdata_i),
    .bus_ack_i            (bus_ack_i),
    .bus_req_o            (bus_req_o),
    .bus_we_o             (bus_we_o),
    .bus_addr_o           (bus_addr_o),
    .bus_sel_o            (bus_sel_o),
    .bus_wdata_o          (bus_wdata_o),
    .stall_req_o          (stall_req_o),
    .wd_o                 (wd_o),
    .wreg_o               (wreg_o),
    .wdata_o              (wdata_o),
    .whilo_o              (whilo_o),
    .hi_o                 (hi_o),
    .lo_o                 (lo_o),
    .cp0_reg_we_o         (cp0_reg_we_o),
    .cp0_reg_write_addr_o (cp0_reg_write_addr_o),
    .cp0_reg_data_o       (cp0_reg_data_o),
    .excp_adel_o          (excp_adel_o),
    .excp_ades_o          (excp_ades_o),
    .bus_err_o            (bus_err_o)
  );

  always #5 clk = ~clk;

  function automatic txn_t mk_exp(input logic [31:0] wdata, input logic wreg,
                                  input logic [3:0] sel, input logic [31:0] bwdata,
                                  input logic [31:0] baddr, input logic we, input int stalls,
                                  input int req_cycles, input int err_cycles);
    txn_t t;
    t.wdata = wdata; t.wreg = wreg; t.sel = sel; t.bwdata = bwdata; t.baddr = baddr;
    t.we = we; t.stalls = stalls; t.req_cycles = req_cycles; t.err_cycles = err_cycles;
    return t;
  endfunction

  task automatic drive_idle();
    aluop_i = OpAddu; mem_addr_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    bus_rdata_i = '0; bus_ack_i = 1'b0;
  endtask

  // Drives one instruction from IDLE and acts as the bus slave: ack is raised
  // in WAIT cycle ack_wait (0 = first), or never when ack_wait < 0.
  task automatic mem_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic wreg,
                         input int ack_wait, output txn_t obs);
    int waits = 0;
    bit done = 0;
    bit req_seen = 0;
    obs = mk_exp('0, 1'b0, '0, '0, '0, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wdata_i = alu; wreg_i = wreg;
    wd_i = 5'd9; bus_rdata_i = rdata; bus_ack_i = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      bus_ack_i = 1'b0;
      if (bus_err_o) obs.err_cycles++;
      if (bus_req_o) obs.req_cycles++;
      if (stall_req_o) begin
        obs.stalls++;
        if (bus_req_o) begin
          if (!req_seen) begin
            obs.sel = bus_sel_o; obs.bwdata = bus_wdata_o; obs.baddr = bus_addr_o;
            obs.we = bus_we_o; req_seen = 1;
          end
          if (ack_wait >= 0 && waits == ack_wait) bus_ack_i = 1'b1;
          waits++;
        end
      end else begin
        obs.wdata = wdata_o; obs.wreg = wreg_o; done = 1;
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL txn_bound: stall never released within 64 cycles (op %b)", op);
    end
  endtask

  task automatic compare_fields(input string name, input txn_t obs, input bit bus_fields);
    txn_t e;
    if (sb_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb_q.pop_front();
    vectors++;
    if (obs.wdata !== e.wdata) begin
      miscompares++; $display("FAIL %s wdata_o: got %h expected %h", name, obs.wdata, e.wdata);
    end
    vectors++;
    if (obs.wreg !== e.wreg) begin
      miscompares++; $display("FAIL %s wreg_o: got %b expected %b", name, obs.wreg, e.wreg);
    end
    vectors++;
    if (obs.stalls !== e.stalls) begin
      miscompares++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, obs.stalls, e.stalls);
    end
    vectors++;
    if (obs.err_cycles !== e.err_cycles) begin
      miscompares++;
      $display("FAIL %s bus_err_cycles: got %0d expected %0d", name, obs.err_cycles, e.err_cycles);
    end
    vectors++;
    if (obs.req_cycles !== e.req_cycles) begin
      miscompares++;
      $display("FAIL %s req_cycles: got %0d expected %0d", name, obs.req_cycles, e.req_cycles);
    end
    if (bus_fields) begin
      vectors++;
      if (obs.sel !== e.sel) begin
        miscompares++; $display("FAIL %s bus_sel_o: got %b expected %b", name, obs.sel, e.sel);
      end
      vectors++;
      if (obs.we !== e.we) begin
        miscompares++; $display("FAIL %s bus_we_o: got %b expected %b", name, obs.we, e.we);
      end
      vectors++;
      if (obs.baddr !== e.baddr) begin
        miscompares++; $display("FAIL %s bus_addr_o: got %h expected %h", name, obs.baddr, e.baddr);
      end
      vectors++;
      if (obs.bwdata !== e.bwdata) begin
        miscompares++;
        $display("FAIL %s bus_wdata_o: got %h expected %h", name, obs.bwdata, e.bwdata);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    aluop_i = OpAddu; wreg_i = 1'b1; wdata_i = 32'h1111_2222; wd_i = 5'd3;
    whilo_i = 1'b1; hi_i = 32'hAAAA_0001; lo_i = 32'hBBBB_0002;
    cp0_reg_we_i = 1'b1; cp0_reg_write_addr_i = 5'd12; cp0_reg_data_i = 32'hCCCC_0003;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({wreg_o, wd_o, wdata_o} !== '0) begin
      miscompares++; $display("FAIL reset_wb: got %b/%h/%h expected zeros", wreg_o, wd_o, wdata_o);
    end
    vectors++;
    if ({whilo_o, hi_o, lo_o} !== '0) begin
      miscompares++; $display("FAIL reset_hilo: got %b/%h/%h expected zeros", whilo_o, hi_o, lo_o);
    end
    vectors++;
    if ({cp0_reg_we_o, cp0_reg_write_addr_o, cp0_reg_data_o} !== '0) begin
      miscompares++; $display("FAIL reset_cp0: got %h expected zeros", cp0_reg_data_o);
    end
    vectors++;
    if ({bus_req_o, bus_we_o, bus_sel_o, stall_req_o, bus_err_o, excp_adel_o, excp_ades_o} !== '0)
    begin
      miscompares++; $display("FAIL reset_ctrl: req %b stall %b err %b expected 0", bus_req_o,
                              stall_req_o, bus_err_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_passthrough();
    txn_t obs;
    whilo_i = 1'b1; hi_i = 32'h0102_0304; lo_i = 32'h0506_0708;
    cp0_reg_we_i = 1'b1; cp0_reg_write_addr_i = 5'd14; cp0_reg_data_i = 32'h9ABC_DEF0;
    sb_q.push_back(mk_exp(32'h0000_4321, 1'b1, '0, '0, '0, 1'b0, 0, 0, 0));
    mem_txn(OpAddu, 32'h0, 32'h0, 32'h0000_4321, 32'h0, 1'b1, 0, obs);
    compare_fields("addu", obs, 0);
    vectors++;
    if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'h0102_0304, 32'h0506_0708}) begin
      miscompares++; $display("FAIL passthru_hilo: got %b/%h/%h expected 1/01020304/05060708",
                              whilo_o, hi_o, lo_o);
    end
    vectors++;
    if ({cp0_reg_we_o, cp0_reg_write_addr_o, cp0_reg_data_o} !== {1'b1, 5'd14, 32'h9ABC_DEF0})
    begin
      miscompares++; $display("FAIL passthru_cp0: got %h expected 9abcdef0", cp0_reg_data_o);
    end
  endtask

  task automatic test_lw();
    txn_t obs;
    sb_q.push_back(mk_exp(32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0, 32'h0000_0100, 1'b0, 2, 1, 0));
    mem_txn(OpLw, 32'h0000_0100, 32'h0, 32'h7777_7777, 32'hDEAD_BEEF, 1'b1, 0, obs);
    compare_fields("lw", obs, 1);
  endtask

  task automatic test_byte_loads();
    txn_t obs;
    sb_q.push_back(mk_exp(32'hFFFF_FFF4, 1'b1, 4'b0100, 32'h0, 32'h0000_0200, 1'b0, 2, 1, 0));
    mem_txn(OpLb, 32'h0000_0201, 32'h0, 32'h0, 32'h12F4_5678, 1'b1, 0, obs);
    compare_fields("lb", obs, 1);
    sb_q.push_back(mk_exp(32'h0000_00F4, 1'b1, 4'b0100, 32'h0, 32'h0000_0200, 1'b0, 2, 1, 0));
    mem_txn(OpLbu, 32'h0000_0201, 32'h0, 32'h0, 32'h12F4_5678, 1'b1, 0, obs);
    compare_fields("lbu", obs, 1);
    // LH at addr ..10, with two extra wait cycles before ack.
    sb_q.push_back(mk_exp(32'hFFFF_8001, 1'b1, 4'b0011, 32'h0, 32'h0000_0400, 1'b0, 4, 3, 0));
    mem_txn(OpLh, 32'h0000_0402, 32'h0, 32'h0, 32'h7FFF_8001, 1'b1, 2, obs);
    compare_fields("lh", obs, 1);
  endtask

  task automatic test_stores();
    txn_t obs;
    sb_q.push_back(mk_exp(32'h00C0_FFEE, 1'b0, 4'b0011, 32'hABCD_ABCD, 32'h0000_0300, 1'b1, 3, 2,
                          0));
    mem_txn(OpSh, 32'h0000_0302, 32'h0000_ABCD, 32'h00C0_FFEE, 32'h0, 1'b0, 1, obs);
    compare_fields("sh", obs, 1);
    sb_q.push_back(mk_exp(32'h0000_0000, 1'b0, 4'b0001, 32'h5A5A_5A5A, 32'h0000_0500, 1'b1, 2, 1,
                          0));
    mem_txn(OpSb, 32'h0000_0503, 32'h1234_565A, 32'h0, 32'h0, 1'b0, 0, obs);
    compare_fields("sb", obs, 1);
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    aluop_i = OpLw; mem_addr_i = 32'h0000_0102; wreg_i = 1'b1; wdata_i = 32'h1;
    @(negedge clk);
    vectors++;
    if ({excp_adel_o, excp_ades_o} !== 2'b10) begin
      miscompares++; $display("FAIL lw_misaligned excp: got %b%b expected 10", excp_adel_o,
                              excp_ades_o);
    end
    vectors++;
    if ({bus_req_o, stall_req_o, wreg_o} !== 3'b000) begin
      miscompares++; $display("FAIL lw_misaligned ctrl: req %b stall %b wreg %b expected 000",
                              bus_req_o, stall_req_o, wreg_o);
    end
    @(posedge clk); #1;
    aluop_i = OpSw; mem_addr_i = 32'h0000_0101;
    @(negedge clk);
    vectors++;
    if ({excp_adel_o, excp_ades_o, bus_req_o, stall_req_o} !== 4'b0100) begin
      miscompares++; $display("FAIL sw_misaligned: adel %b ades %b req %b stall %b expected 0100",
                              excp_adel_o, excp_ades_o, bus_req_o, stall_req_o);
    end
    drive_idle();
  endtask

  task automatic test_timeout();
    txn_t obs;
    sb_q.push_back(mk_exp(32'h0, 1'b0, 4'b1111, 32'h0, 32'h0000_0600, 1'b0, Tmo + 1, Tmo, 1));
    mem_txn(OpLw, 32'h0000_0600, 32'h0, 32'h0, 32'h1234_5678, 1'b1, -1, obs);
    compare_fields("timeout", obs, 1);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    vectors++;
    if ({bus_err_o, bus_req_o, stall_req_o} !== 3'b000) begin
      miscompares++; $display("FAIL timeout_after: err %b req %b stall %b expected 000", bus_err_o,
                              bus_req_o, stall_req_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    txn_t obs;
    @(posedge clk); #1;
    aluop_i = OpLw; mem_addr_i = 32'h0000_0700; wreg_i = 1'b1; bus_ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({bus_req_o, stall_req_o} !== 2'b11) begin
      miscompares++; $display("FAIL mid_wait_pre: req %b stall %b expected 11", bus_req_o,
                              stall_req_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    aluop_i = OpAddu; mem_addr_i = '0; wreg_i = 1'b1; wdata_i = 32'h0000_1234;
    @(negedge clk);
    vectors++;
    if ({bus_req_o, stall_req_o, wreg_o} !== 3'b001 || wdata_o !== 32'h0000_1234) begin
      miscompares++; $display("FAIL mid_wait_reset: req %b stall %b wreg %b wdata %h expected 001/1234",
                              bus_req_o, stall_req_o, wreg_o, wdata_o);
    end
    sb_q.push_back(mk_exp(32'hCAFE_F00D, 1'b1, 4'b1111, 32'h0, 32'h0000_0800, 1'b0, 2, 1, 0));
    mem_txn(OpLw, 32'h0000_0800, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b1, 0, obs);
    compare_fields("lw_after_reset", obs, 1);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    whilo_i = 1'b0; hi_i = '0; lo_i = '0;
    cp0_reg_we_i = 1'b0; cp0_reg_write_addr_i = '0; cp0_reg_data_i = '0;
    test_reset();
    test_passthrough();
    test_lw();
    test_byte_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
